// File: rtl/data_memory_if.sv
// data_memory_if: core-side load/store bus for the data memory
interface data_memory_if #(parameter int bus = 32);
  logic [bus-1:0] memdir;
  logic [bus-1:0] memdataout;
  logic           MRE;
  logic           MWE;
  logic [bus-1:0] memdatain;
  modport master (output memdir, memdataout, MRE, MWE, input memdatain);
  modport slave (input memdir, memdataout, MRE, MWE, output memdatain);
endinterface

// File: rtl/data_memory.sv
// data_memory: word RAM plus GPIO, free-running cycle timer with compare, and sticky status flags
module data_memory #(
  parameter int bus = 32,
  parameter int WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_if.slave     mem,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out,
  output logic             fault
);
  localparam int AW = WORDS > 1 ? $clog2(WORDS) : 1;
  logic [bus-1:0] ram [WORDS];
  logic [bus-1:0] addr, cycle, cmp;
  logic [AW-1:0]  idx;
  logic [7:0]     sync1, sync2;
  logic           match;
  logic           ram_sel, sel_out, sel_in, sel_cyc, sel_cmp, sel_st, bad, wr, wr_st;
  // address decode on the word-aligned address
  always_comb begin
    addr    = mem.memdir & ~bus'(3);
    idx     = addr[AW+1:2];
    ram_sel = addr < bus'(4 * WORDS);
    sel_out = addr == bus'('h400);
    sel_in  = addr == bus'('h404);
    sel_cyc = addr == bus'('h408);
    sel_cmp = addr == bus'('h40C);
    sel_st  = addr == bus'('h410);
    bad     = (mem.MRE | mem.MWE) & ~(ram_sel | sel_out | sel_in | sel_cyc | sel_cmp | sel_st);
    wr      = mem.MWE;
    wr_st   = wr & sel_st;
  end
  assign mem.memdatain = !mem.MRE ? '0 :
                         ram_sel  ? ram[idx] :
                         sel_out  ? bus'(gpio_out) :
                         sel_in   ? bus'(sync2) :
                         sel_cyc  ? cycle :
                         sel_cmp  ? cmp :
                         sel_st   ? bus'({fault, match}) : '0;
  // RAM is never reset; a write on an edge that falls inside reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && wr && ram_sel) ram[idx] <= mem.memdataout;
  end
  // two-flop synchronizer for the asynchronous GPIO inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end
  // peripheral registers; set beats write-1-to-clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
      cycle    <= '0;
      cmp      <= '0;
      match    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      cycle <= cycle + bus'(1);
      if (wr && sel_out) gpio_out <= mem.memdataout[7:0];
      if (wr && sel_cmp) cmp <= mem.memdataout;
      match <= (cycle == cmp && cmp != '0) || (match && !(wr_st && mem.memdataout[0]));
      fault <= bad || (fault && !(wr_st && mem.memdataout[1]));
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       fault;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  data_memory_if #(.bus(32)) mem ();
  data_memory #(.bus(32), .WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem), .gpio_in(gpio_in), .gpio_out(gpio_out), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    mem.MRE = re;
    mem.MWE = we;
    mem.memdir = a;
    mem.memdataout = d;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    cyc = rst_n ? cyc + 1 : 0;
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    chk(tag, mem.memdatain, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick();
  endtask
  initial begin
    rst_n = 1'b0;
    gpio_in = 8'h00;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #10;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    rd(32'h408, "rst_cycle", 32'h0);
    rd(32'h410, "rst_status", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(32'h408, "cycle_first", 32'd1);
    wr(32'h40C, 32'd20);
    rd(32'h410, "status_pre_match", 32'h0);
    rd(32'h408, "cycle_after_cmp", 32'd2);
    repeat (25) tick();
    rd(32'h410, "status_match", 32'h1);
    wr(32'h410, 32'h1);
    rd(32'h410, "status_cleared", 32'h0);
    wr(32'h40C, 32'h0);
    rd(32'h40C, "cmp_zero", 32'h0);
    repeat (2) tick();
    rd(32'h410, "cmp0_no_match", 32'h0);
    rd(32'h408, "cycle_31", 32'd31);
    wr(32'h40C, cyc + 2);
    tick();
    wr(32'h410, 32'h1);
    rd(32'h410, "match_set_wins", 32'h1);
    wr(32'h410, 32'h0);
    rd(32'h410, "status_write0", 32'h1);
    wr(32'h410, 32'h1);
    rd(32'h410, "status_clear2", 32'h0);
    wr(32'h008, 32'hDEADBEEF);
    rd(32'h008, "ram_rd_008", 32'hDEADBEEF);
    rd(32'h00B, "ram_rd_00b", 32'hDEADBEEF);
    drive(1'b0, 1'b0, 32'h008, 32'h0);
    chk("mre0_zero", mem.memdatain, 32'h0);
    wr(32'h010, 32'h11);
    drive(1'b1, 1'b1, 32'h010, 32'h22);
    chk("rw_prewrite", mem.memdatain, 32'h11);
    tick();
    rd(32'h010, "rw_postwrite", 32'h22);
    rd(32'h800, "unmapped_rd", 32'h0);
    tick();
    chk("fault_set", 32'(fault), 32'h1);
    rd(32'h410, "status_fault", 32'h2);
    drive(1'b0, 1'b1, 32'h804, 32'h2);
    tick();
    chk("fault_held", 32'(fault), 32'h1);
    wr(32'h410, 32'h2);
    chk("fault_clear", 32'(fault), 32'h0);
    wr(32'h400, 32'h1A5);
    chk("gpio_out_a5", 32'(gpio_out), 32'hA5);
    rd(32'h400, "gpio_out_rd", 32'hA5);
    gpio_in = 8'h3C;
    rd(32'h404, "gpio_in_edge0", 32'h0);
    tick();
    rd(32'h404, "gpio_in_edge1", 32'h0);
    tick();
    rd(32'h404, "gpio_in_edge2", 32'h3C);
    wr(32'h400, 32'hFF);
    wr(32'h000, 32'd7);
    rd(32'h800, "unmapped_rd2", 32'h0);
    tick();
    while (cyc < 50) tick();
    rd(32'h408, "cycle_50", 32'd50);
    chk("gpio_out_ff", 32'(gpio_out), 32'hFF);
    chk("fault_pre_rst", 32'(fault), 32'h1);
    #2;
    rst_n = 1'b0;
    rd(32'h408, "mid_rst_cycle", 32'h0);
    chk("mid_rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("mid_rst_fault", 32'(fault), 32'h0);
    rd(32'h000, "mid_rst_ram0", 32'd7);
    rd(32'h008, "mid_rst_ram8", 32'hDEADBEEF);
    wr(32'h000, 32'd9);
    rd(32'h000, "rst_write_dropped", 32'd7);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rd(32'h408, "cycle_restart", 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
